// File: rtl/ldtu_output_fifo.sv
// Output FIFO between the LiteDTU control unit and the serializer. It gives almost-full
// back-pressure, returns an idle word on underflow, and counts dropped writes with saturation.
module ldtu_output_fifo #(
  parameter int unsigned         Nbits_32       = 32,
  parameter int unsigned         FifoDepth_buff = 64,
  parameter int unsigned         bits_ptr       = 6,
  parameter int unsigned         AF_MARGIN      = 2,
  parameter logic [Nbits_32-1:0] IdlePattern    = 32'hEAAAAAAA
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                write_signal,
  input  logic [Nbits_32-1:0] DATA_in,
  input  logic                read_signal,
  output logic                full,
  output logic                empty,
  output logic [Nbits_32-1:0] DATA_out,
  output logic                data_valid,
  output logic                overflow,
  output logic [7:0]          ovf_count,
  output logic [bits_ptr:0]   occupancy
);

  localparam int unsigned OCC_W = bits_ptr + 1;
  localparam logic [bits_ptr:0]   OCC_ZERO_C  = OCC_W'(0);
  localparam logic [bits_ptr:0]   OCC_ONE_C   = OCC_W'(1);
  localparam logic [bits_ptr:0]   DEPTH_C     = OCC_W'(FifoDepth_buff);
  localparam logic [bits_ptr:0]   AF_THRESH_C = OCC_W'(FifoDepth_buff - AF_MARGIN);
  localparam logic [bits_ptr-1:0] PTR_ONE_C   = bits_ptr'(1);

  logic [Nbits_32-1:0] mem_r [FifoDepth_buff];
  logic [bits_ptr-1:0] wr_ptr_r;
  logic [bits_ptr-1:0] rd_ptr_r;
  logic [bits_ptr:0]   occ_r;
  logic                full_r;
  logic                empty_r;
  logic [Nbits_32-1:0] data_out_r;
  logic                data_valid_r;
  logic                overflow_r;
  logic [7:0]          ovf_count_r;

  logic                rd_ok_s;
  logic                wr_ok_s;
  logic                drop_s;
  logic [bits_ptr:0]   occ_next_s;

  // Accept/drop decisions and next occupancy; a read frees a slot for a write at full depth.
  always_comb begin
    rd_ok_s    = 1'b0;
    wr_ok_s    = 1'b0;
    drop_s     = 1'b0;
    occ_next_s = occ_r;
    rd_ok_s = read_signal && (occ_r != OCC_ZERO_C);
    wr_ok_s = write_signal && ((occ_r < DEPTH_C) || rd_ok_s);
    drop_s  = write_signal && !wr_ok_s;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   occ_next_s = occ_r + OCC_ONE_C;
      2'b01:   occ_next_s = occ_r - OCC_ONE_C;
      default: occ_next_s = occ_r;
    endcase
  end

  // Storage array, deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= DATA_in;
    end
  end

  // Pointers, status flags, read port and overflow bookkeeping.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wr_ptr_r     <= {bits_ptr{1'b0}};
      rd_ptr_r     <= {bits_ptr{1'b0}};
      occ_r        <= OCC_ZERO_C;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      data_out_r   <= IdlePattern;
      data_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      ovf_count_r  <= 8'h00;
    end else begin
      occ_r   <= occ_next_s;
      full_r  <= (occ_next_s >= AF_THRESH_C);
      empty_r <= (occ_next_s == OCC_ZERO_C);
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (rd_ok_s) begin
        data_out_r   <= mem_r[rd_ptr_r];
        data_valid_r <= 1'b1;
        rd_ptr_r     <= rd_ptr_r + PTR_ONE_C;
      end else begin
        data_valid_r <= 1'b0;
        if (read_signal) begin
          data_out_r <= IdlePattern;
        end
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (ovf_count_r != 8'hFF) begin
          ovf_count_r <= ovf_count_r + 8'd1;
        end
      end
    end
  end

  assign full       = full_r;
  assign empty      = empty_r;
  assign DATA_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign overflow   = overflow_r;
  assign ovf_count  = ovf_count_r;
  assign occupancy  = occ_r;

endmodule

// File: tb/tb_ldtu_output_fifo.sv
// Directed bench for ldtu_output_fifo: a vector table for basic traffic, then sequences
// for fill/overflow, full-depth read+write, wrap-around bursts and mid-burst reset.
module tb_ldtu_output_fifo;

  localparam logic [31:0] IDLE = 32'hEAAAAAAA;

  logic        CLK;
  logic        rst;
  logic        write_signal;
  logic [31:0] DATA_in;
  logic        read_signal;
  logic        full;
  logic        empty;
  logic [31:0] DATA_out;
  logic        data_valid;
  logic        overflow;
  logic [7:0]  ovf_count;
  logic [6:0]  occupancy;

  int checks = 0;
  int errors = 0;

  logic [31:0] q [$];
  logic [31:0] m_dout;
  logic        m_vld;
  logic        m_ovf;
  logic [7:0]  m_cnt;

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] d;
    logic [31:0] dout;
    logic        vld;
    logic        emp;
    logic [6:0]  occ;
  } vec_t;

  vec_t tbl [10];

  ldtu_output_fifo dut (
    .CLK          (CLK),
    .rst          (rst),
    .write_signal (write_signal),
    .DATA_in      (DATA_in),
    .read_signal  (read_signal),
    .full         (full),
    .empty        (empty),
    .DATA_out     (DATA_out),
    .data_valid   (data_valid),
    .overflow     (overflow),
    .ovf_count    (ovf_count),
    .occupancy    (occupancy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle against the reference model, then compare every output.
  task automatic cyc(input logic w, input logic r, input logic [31:0] d);
    logic rd_ok;
    logic wr_ok;
    write_signal = w;
    read_signal  = r;
    DATA_in      = d;
    @(posedge CLK);
    #1;
    rd_ok = r && (q.size() != 0);
    wr_ok = w && ((q.size() < 64) || rd_ok);
    if (rd_ok) begin
      m_dout = q.pop_front();
      m_vld  = 1'b1;
    end else begin
      m_vld = 1'b0;
      if (r) m_dout = IDLE;
    end
    if (wr_ok) begin
      q.push_back(d);
    end else if (w) begin
      m_ovf = 1'b1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    chk("dout", DATA_out, m_dout);
    chk("valid", 32'(data_valid), 32'(m_vld));
    chk("occ", 32'(occupancy), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() >= 62));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_occ"}, 32'(occupancy), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_dout"}, DATA_out, IDLE);
    chk({tag, "_valid"}, 32'(data_valid), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_ovf_count"}, 32'(ovf_count), 32'd0);
  endtask

  initial begin
    int sent;
    int bi;
    tbl[0] = '{1'b0, 1'b1, 32'h0,        IDLE,         1'b0, 1'b1, 7'd0};
    tbl[1] = '{1'b0, 1'b1, 32'h0,        IDLE,         1'b0, 1'b1, 7'd0};
    tbl[2] = '{1'b0, 1'b1, 32'h0,        IDLE,         1'b0, 1'b1, 7'd0};
    tbl[3] = '{1'b1, 1'b0, 32'h12345678, IDLE,         1'b0, 1'b0, 7'd1};
    tbl[4] = '{1'b1, 1'b0, 32'h9ABCDEF0, IDLE,         1'b0, 1'b0, 7'd2};
    tbl[5] = '{1'b0, 1'b1, 32'h0,        32'h12345678, 1'b1, 1'b0, 7'd1};
    tbl[6] = '{1'b0, 1'b1, 32'h0,        32'h9ABCDEF0, 1'b1, 1'b1, 7'd0};
    tbl[7] = '{1'b0, 1'b0, 32'h0,        32'h9ABCDEF0, 1'b0, 1'b1, 7'd0};
    tbl[8] = '{1'b1, 1'b1, 32'h00000055, IDLE,         1'b0, 1'b0, 7'd1};
    tbl[9] = '{1'b0, 1'b1, 32'h0,        32'h00000055, 1'b1, 1'b1, 7'd0};

    rst = 1'b0;
    write_signal = 1'b0;
    read_signal = 1'b0;
    DATA_in = 32'h0;
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("por");
    @(negedge CLK);
    rst = 1'b0;

    // Underflow reads, basic ordering, and write-while-empty with no bypass.
    for (int i = 0; i < 10; i++) begin
      write_signal = tbl[i].w;
      read_signal  = tbl[i].r;
      DATA_in      = tbl[i].d;
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_dout", i), DATA_out, tbl[i].dout);
      chk($sformatf("vec%0d_valid", i), 32'(data_valid), 32'(tbl[i].vld));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(tbl[i].occ));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'd0);
    end

    q.delete();
    m_dout = 32'h00000055;
    m_vld  = 1'b0;
    m_ovf  = 1'b0;
    m_cnt  = 8'h00;

    // Fill to the almost-full threshold, then to depth, then overflow and saturate.
    for (int i = 0; i < 62; i++) cyc(1'b1, 1'b0, 32'hA0000000 + 32'(i));
    chk("t3_full_at_62", 32'(full), 32'd1);
    cyc(1'b1, 1'b0, 32'hA000003E);
    cyc(1'b1, 1'b0, 32'hA000003F);
    chk("t3_occ_64", 32'(occupancy), 32'd64);
    chk("t3_no_ovf", 32'(overflow), 32'd0);
    cyc(1'b1, 1'b0, 32'hDEAD0000);
    chk("t3_ovf_cnt_1", 32'(ovf_count), 32'd1);
    chk("t3_occ_stays_64", 32'(occupancy), 32'd64);

    // Simultaneous read and write at full depth.
    cyc(1'b1, 1'b1, 32'hBEEF0001);
    chk("t4_oldest", DATA_out, 32'hA0000000);
    chk("t4_occ", 32'(occupancy), 32'd64);
    chk("t4_cnt", 32'(ovf_count), 32'd1);

    for (int i = 0; i < 258; i++) cyc(1'b1, 1'b0, 32'hDEAD0001);
    chk("t3_ovf_sat", 32'(ovf_count), 32'hFF);
    while (q.size() != 0) cyc(1'b0, 1'b1, 32'h0);
    cyc(1'b0, 1'b1, 32'h0);

    // Interleaved bursts, 200 words, pointers wrap several times.
    sent = 0;
    bi = 0;
    while (sent < 200) begin
      for (int k = 0; k <= (bi % 7); k++) begin
        if (sent < 200) begin
          cyc(1'b1, (k % 3) == 2, 32'hC0000000 + 32'(sent));
          sent++;
        end
      end
      for (int k = 0; k <= (bi % 5); k++) cyc(1'b0, 1'b1, 32'h0);
      bi++;
    end
    while (q.size() != 0) cyc(1'b0, 1'b1, 32'h0);
    cyc(1'b0, 1'b1, 32'h0);

    // Reset in the middle of a burst at occupancy 10.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 32'h50000000 + 32'(i));
    chk("t6_occ_10", 32'(occupancy), 32'd10);
    write_signal = 1'b0;
    read_signal  = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_vals("async");
    @(negedge CLK);
    rst = 1'b0;
    q.delete();
    m_dout = IDLE;
    m_vld  = 1'b0;
    m_ovf  = 1'b0;
    m_cnt  = 8'h00;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
